fr_exp_inv_search: RTL

- Inverse of the exp(-x) lookup. Given a scaled exponential value y, returns the smallest table index i with EXP_TBL[i] <= y, i.e. x ≈ -100*ln(y/100).
- Used by the feature-recovery path to map normalised amplitudes (0..100) back to the distance/time domain.
- The lookup is a fixed-iteration binary search over a monotonic non-increasing 392-entry ROM with a registered read.

---
 rtl/fr_exp_pkg.sv | 42 ++++
 rtl/fr_exp_inv_search_if.sv | 27 ++
 rtl/fr_exp_rom.sv | 30 +++
 rtl/fr_exp_inv_search.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fr_exp_pkg.sv
// fr_exp_pkg: shared constants, FSM state type and exp(-x) table contents for
// the forward exp(-x) LUT and its inverse search (fr_exp_inv_search).
// No ports. The table is generated by a constant function so both directions
// use bit-identical data:
//   EXP_TBL[i] = floor(100 * exp(-i/100)), i = 0..EXP_DEPTH-1, 9-bit unsigned.
package fr_exp_pkg;

  localparam int EXP_DEPTH = 392;
  localparam int EXP_AW    = 9;
  localparam int EXP_SCALE = 100;
  localparam int EXP_MIN   = 2;
  localparam int EXP_TW    = 9;

  // round(exp(-1/100) * 2^32): per-index decay factor in Q32
  localparam logic [31:0] EXP_STEP_C = 32'd4252231657;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CMP  = 2'd2,
    FIN  = 2'd3
  } exp_state_e;

  typedef logic [EXP_DEPTH-1:0][EXP_TW-1:0] exp_tbl_t;

  // Builds the whole table by repeated Q32 multiplication starting from 100.0;
  // the integer part of the accumulator is floor(100*exp(-i/100)). Truncation
  // error stays far below the distance of any entry to an integer boundary.
  function automatic exp_tbl_t exp_tbl_build();
    exp_tbl_t    tbl;
    logic [63:0] acc;
    logic [95:0] prod;
    acc = 64'(EXP_SCALE) << 32;
    for (int i = 0; i < EXP_DEPTH; i++) begin
      tbl[i] = acc[32 +: EXP_TW];
      prod   = {32'd0, acc} * {64'd0, EXP_STEP_C};
      acc    = 64'(prod >> 32);
    end
    return tbl;
  endfunction

endpackage

// File: rtl/fr_exp_inv_search_if.sv
// fr_exp_inv_search_if: request/result bundle of the inverse exp search.
//   start  master->slave  request strobe
//   idata  master->slave  signed target value y (100 = 1.0)
//   busy   slave->master  search in progress
//   odata  slave->master  result index, zero-extended
//   done   slave->master  one-cycle result strobe
//   sat    slave->master  result clamped (only with FR_EXP_INV_SAT_FLAG_EN)
interface fr_exp_inv_search_if #(
  parameter int DW = 16
) ();

  logic                 start;
  logic signed [DW-1:0] idata;
  logic                 busy;
  logic [DW-1:0]        odata;
  logic                 done;
`ifdef FR_EXP_INV_SAT_FLAG_EN
  logic                 sat;

  modport master (output start, idata, input busy, odata, done, sat);
  modport slave  (input start, idata, output busy, odata, done, sat);
`else
  modport master (output start, idata, input busy, odata, done);
  modport slave  (input start, idata, output busy, odata, done);
`endif

endinterface

// File: rtl/fr_exp_rom.sv
// fr_exp_rom: synchronous single-port ROM holding the exp(-x) table.
//   clk     in   clock
//   addr_i  in   table index
//   data_o  out  EXP_TBL[addr], registered (one cycle latency, no reset)
module fr_exp_rom
  import fr_exp_pkg::*;
#(
  parameter int AW = EXP_AW
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr_i,
  output logic [EXP_TW-1:0] data_o
);

  localparam exp_tbl_t TBL = exp_tbl_build();

  logic [EXP_TW-1:0] data_q;

  // Registered table read; indices past the table return the floor value.
  always_ff @(posedge clk) begin
    if (int'(addr_i) < EXP_DEPTH) begin
      data_q <= TBL[addr_i];
    end else begin
      data_q <= EXP_TW'(EXP_MIN);
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fr_exp_inv_search.sv
// fr_exp_inv_search: inverse of the exp(-x) lookup. Returns the smallest index
// i with EXP_TBL[i] <= y_eff using a fixed 9-step binary search over fr_exp_rom.
// Latency from accepted start to done is always 2*ITER+1 cycles.
//   clk  in  clock (rising edge)
//   rst  in  synchronous active-high reset
//   bus  fr_exp_inv_search_if.slave: start/idata in, busy/odata/done out
// Optional build macro FR_EXP_INV_SAT_FLAG_EN adds bus.sat: set with the
// result when the input had to be clamped (y_eff < 2 or idata > 100).
module fr_exp_inv_search
  import fr_exp_pkg::*;
#(
  parameter int DEPTH = EXP_DEPTH,
  parameter int AW    = EXP_AW,
  parameter int ITER  = 9,
  parameter int DW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  fr_exp_inv_search_if.slave bus
);

  localparam int              IW       = $clog2(ITER + 1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [DW-1:0]   Y_CLAMP  = DW'(2 ** EXP_TW - 1);

  exp_state_e        state_q, state_d;
  logic [AW-1:0]     lo_q, lo_d, hi_q, hi_d, mid_s;
  logic [IW-1:0]     it_q, it_d;
  logic [EXP_TW-1:0] y_q, y_d, y_eff_s, rom_data_s;
  logic              busy_q, busy_d, done_q, done_d;
  logic [DW-1:0]     odata_q, odata_d;
`ifdef FR_EXP_INV_SAT_FLAG_EN
  logic              sat_in_s, sat_pend_q, sat_pend_d, sat_q, sat_d;
`endif

  // lo+hi is formed at AW+1 bits so the midpoint never overflows.
  assign mid_s = AW'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);

  fr_exp_rom #(.AW(AW)) u_rom (
    .clk    (clk),
    .addr_i (mid_s),
    .data_o (rom_data_s)
  );

  // Clamp the signed request into the 9-bit comparison range.
  always_comb begin
    y_eff_s = bus.idata[EXP_TW-1:0];
    if (bus.idata[DW-1]) begin
      y_eff_s = '0;
    end else if (bus.idata > Y_CLAMP) begin
      y_eff_s = Y_CLAMP[EXP_TW-1:0];
    end else begin
      y_eff_s = bus.idata[EXP_TW-1:0];
    end
  end

`ifdef FR_EXP_INV_SAT_FLAG_EN
  // Clamp detection at acceptance time.
  always_comb begin
    if (y_eff_s < EXP_TW'(EXP_MIN)) begin
      sat_in_s = 1'b1;
    end else if (!bus.idata[DW-1] && (bus.idata > DW'(EXP_SCALE))) begin
      sat_in_s = 1'b1;
    end else begin
      sat_in_s = 1'b0;
    end
  end
`endif

  // Search FSM: next state, search window update and result capture.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    it_d    = it_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    odata_d = odata_q;
`ifdef FR_EXP_INV_SAT_FLAG_EN
    sat_pend_d = sat_pend_q;
    sat_d      = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          y_d     = y_eff_s;
          lo_d    = '0;
          hi_d    = LAST_IDX;
          it_d    = '0;
          busy_d  = 1'b1;
          state_d = ADDR;
`ifdef FR_EXP_INV_SAT_FLAG_EN
          sat_pend_d = sat_in_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        state_d = CMP;
      end
      CMP: begin
        // Once the window has collapsed it must stay put, otherwise lo
        // would step past hi on a failing compare.
        if (lo_q != hi_q) begin
          if (rom_data_s <= y_q) begin
            hi_d = mid_s;
          end else begin
            lo_d = mid_s + AW'(1);
          end
        end else begin
          lo_d = lo_q;
        end
        it_d = it_q + IW'(1);
        // Outputs are registered, so FIN's values are loaded on entry.
        if (it_d == IW'(ITER)) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          odata_d = DW'(lo_d);
`ifdef FR_EXP_INV_SAT_FLAG_EN
          sat_d   = sat_pend_q;
`endif
        end else begin
          state_d = ADDR;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      it_q    <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      odata_q <= '0;
`ifdef FR_EXP_INV_SAT_FLAG_EN
      sat_pend_q <= 1'b0;
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      it_q    <= it_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      odata_q <= odata_d;
`ifdef FR_EXP_INV_SAT_FLAG_EN
      sat_pend_q <= sat_pend_d;
      sat_q      <= sat_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.odata = odata_q;
`ifdef FR_EXP_INV_SAT_FLAG_EN
  assign bus.sat   = sat_q;
`endif

endmodule
